// File: rtl/hazard3_ahbl_arb2.sv
// hazard3_ahbl_arb2
// Two-manager to one-subordinate AHB-Lite arbiter with round-robin priority,
// locked-sequence holding and a one-entry address-phase skid buffer per manager.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   m0_* / m1_* (inputs)     manager address-phase request and write data
//   m0_* / m1_* (outputs)    hready, hresp, hexokay, hrdata back to each manager
//   s_* (outputs)            arbitrated request and write data to the subordinate
//   s_hready, s_hresp,
//   s_hexokay, s_hrdata      subordinate response
module hazard3_ahbl_arb2 #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [W_ADDR-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hexcl,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic [W_DATA-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic              m0_hexokay,
  output logic [W_DATA-1:0] m0_hrdata,

  input  logic [W_ADDR-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hexcl,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic [W_DATA-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic              m1_hexokay,
  output logic [W_DATA-1:0] m1_hrdata,

  output logic [W_ADDR-1:0] s_haddr,
  output logic              s_hwrite,
  output logic [1:0]        s_htrans,
  output logic              s_hexcl,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [3:0]        s_hprot,
  output logic              s_hmastlock,
  output logic [W_DATA-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic              s_hresp,
  input  logic              s_hexokay,
  input  logic [W_DATA-1:0] s_hrdata
);

  // Address-phase request packed as {haddr, hwrite, htrans, hexcl, hsize,
  // hburst, hprot, hmastlock}; hmastlock sits in bit 0.
  localparam int W_REQ = W_ADDR + 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DPH  = 2'd2;

  logic [1:0]       state0, state1;
  logic [W_REQ-1:0] m0_req, m1_req;
  logic [W_REQ-1:0] buf0, buf1;
  logic [W_REQ-1:0] held_req, sel_req, out_req;
  logic [1:0]       out_htrans;

  logic last_grant;   // manager issued most recently (round-robin pointer)
  logic lock_valid;   // a locked sequence is in progress
  logic lock_mgr;     // manager owning the locked sequence
  logic dph_valid;    // downstream data phase belongs to a manager
  logic dph_mgr;      // which manager owns the downstream data phase

  logic hready0, hready1;
  logic live0, live1, pend0, pend1;
  logic can0, can1;
  logic [1:0] cand;
  logic issue, grant;

  assign m0_req = {m0_haddr, m0_hwrite, m0_htrans, m0_hexcl, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock};
  assign m1_req = {m1_haddr, m1_hwrite, m1_htrans, m1_hexcl, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock};

  // Manager-facing hready follows the per-manager state; reset forces it high.
  assign hready0 = rst || (state0 == ST_IDLE) || ((state0 == ST_DPH) && s_hready);
  assign hready1 = rst || (state1 == ST_IDLE) || ((state1 == ST_DPH) && s_hready);

  assign live0 = !rst && m0_htrans[1] && hready0;
  assign live1 = !rst && m1_htrans[1] && hready1;
  assign pend0 = (state0 == ST_PEND);
  assign pend1 = (state1 == ST_PEND);

  // Arbitration: a held lock excludes the other manager, buffered requests
  // outrank live ones, and a tie goes to the manager not granted last.
  always_comb begin
    can0 = !lock_valid || !lock_mgr;
    can1 = !lock_valid || lock_mgr;
    if ((can0 && pend0) || (can1 && pend1))
      cand = {can1 && pend1, can0 && pend0};
    else
      cand = {can1 && live1, can0 && live0};
    issue = s_hready && !rst && (cand != 2'b00);
    grant = (cand == 2'b11) ? !last_grant : cand[1];
    if (grant)
      sel_req = pend1 ? buf1 : m1_req;
    else
      sel_req = pend0 ? buf0 : m0_req;
    out_req = issue ? sel_req : held_req;
  end

  assign {s_haddr, s_hwrite, out_htrans, s_hexcl, s_hsize, s_hburst, s_hprot, s_hmastlock} = out_req;
  assign s_htrans = issue ? out_htrans : 2'b00;

  // Per-manager state, skid buffers, pointer, lock and data-phase owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state0     <= ST_IDLE;
      state1     <= ST_IDLE;
      buf0       <= '0;
      buf1       <= '0;
      held_req   <= '0;
      last_grant <= 1'b0;
      lock_valid <= 1'b0;
      lock_mgr   <= 1'b0;
      dph_valid  <= 1'b0;
      dph_mgr    <= 1'b0;
    end else begin
      if (issue) begin
        last_grant <= grant;
        held_req   <= sel_req;
        lock_valid <= sel_req[0];
        lock_mgr   <= grant;
      end
      if (s_hready) begin
        dph_valid <= issue;
        dph_mgr   <= grant;
      end

      if (issue && !grant)
        state0 <= ST_DPH;
      else if (live0)
        state0 <= ST_PEND;
      else if ((state0 == ST_DPH) && s_hready)
        state0 <= ST_IDLE;

      if (issue && grant)
        state1 <= ST_DPH;
      else if (live1)
        state1 <= ST_PEND;
      else if ((state1 == ST_DPH) && s_hready)
        state1 <= ST_IDLE;

      if (live0 && !(issue && !grant))
        buf0 <= m0_req;
      if (live1 && !(issue && grant))
        buf1 <= m1_req;
    end
  end

  assign m0_hready = hready0;
  assign m1_hready = hready1;

  // Response routing: only the data-phase owner sees the subordinate response.
  assign s_hwdata   = dph_mgr ? m1_hwdata : m0_hwdata;
  assign m0_hresp   = dph_valid && !dph_mgr && s_hresp;
  assign m1_hresp   = dph_valid && dph_mgr && s_hresp;
  assign m0_hexokay = dph_valid && !dph_mgr && s_hexokay;
  assign m1_hexokay = dph_valid && dph_mgr && s_hexokay;
  assign m0_hrdata  = (dph_valid && !dph_mgr) ? s_hrdata : '0;
  assign m1_hrdata  = (dph_valid && dph_mgr) ? s_hrdata : '0;

endmodule
